// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch request/response controller.
// Issues word-aligned fetches under a credit limit of MAX_OUTSTANDING
// (credits cover requests in flight plus words waiting in the response
// FIFO). It also tracks the PC of each outstanding request, discards
// responses made stale by a redirect, and hands words to the fetch buffer.
// Optional feature: define FETCH_BYPASS_EN to forward a live response
// straight to buf_* in the same cycle. This applies only when the FIFO is
// empty and the buffer is not stalled.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rerror,
  input  logic        buf_stall,
  output logic        buf_ready,
  output logic [31:0] buf_pc,
  output logic [31:0] buf_rdata,
  output logic        buf_error,
  output logic        buf_clear
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [3:0] CREDITS  = 4'(MAX_OUTSTANDING);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] fpc;
  logic [2:0]  outstanding;
  logic [2:0]  outstanding_nxt;
  logic [2:0]  stale;
  logic [2:0]  stale_nxt;

  // PC of every outstanding request, oldest at pcq_rd (4 slots cover the max credit)
  logic [31:0] pcq [4];
  logic [1:0]  pcq_wr;
  logic [1:0]  pcq_rd;

  // Response FIFO storage
  logic [31:0] fifo_pc   [4];
  logic [31:0] fifo_data [4];
  logic [3:0]  fifo_err;
  logic [1:0]  fifo_wr;
  logic [1:0]  fifo_rd;
  logic [2:0]  fifo_cnt;

  logic        fifo_nempty;
  logic        accept;
  logic        rsp;
  logic        rsp_live;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [31:0] rsp_pc;

  // Request credit, response classification and next-state control
  always_comb begin
    fifo_nempty = (fifo_cnt != 3'd0);
    mem_addr    = {fpc[31:2], 2'b00};
    mem_valid   = (state != ST_IDLE) &&
                  (({1'b0, outstanding} + {1'b0, fifo_cnt}) < CREDITS) &&
                  !redirect_valid;
    accept      = mem_valid && mem_ready;
    // a response with nothing outstanding is a protocol error; ignore it
    rsp         = mem_rvalid && (outstanding != 3'd0);
    rsp_live    = rsp && !redirect_valid && (stale == 3'd0);
    rsp_pc      = pcq[pcq_rd];
`ifdef FETCH_BYPASS_EN
    bypass      = rsp_live && !fifo_nempty && !buf_stall;
`else
    bypass      = 1'b0;
`endif
    push        = rsp_live && !bypass;
    pop         = fifo_nempty && !buf_stall;

    outstanding_nxt = outstanding + {2'b00, accept} - {2'b00, rsp};

    // on redirect everything still in flight after this cycle becomes stale
    if (redirect_valid) begin
      stale_nxt = outstanding_nxt;
    end else if (rsp && (stale != 3'd0)) begin
      stale_nxt = stale - 3'd1;
    end else begin
      stale_nxt = stale;
    end

    if (state == ST_IDLE) begin
      state_nxt = ST_RUN;
    end else if (stale_nxt != 3'd0) begin
      state_nxt = ST_DRAIN;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  // Fetch buffer interface: bypassed response, else FIFO head, else zeros
  always_comb begin
    buf_ready = fifo_nempty;
    buf_pc    = 32'd0;
    buf_rdata = 32'd0;
    buf_error = 1'b0;
    buf_clear = (state == ST_IDLE) || redirect_valid;
    if (bypass) begin
      buf_ready = 1'b1;
      buf_pc    = rsp_pc;
      buf_rdata = mem_rdata;
      buf_error = mem_rerror;
    end else if (fifo_nempty) begin
      buf_pc    = fifo_pc[fifo_rd];
      buf_rdata = fifo_data[fifo_rd];
      buf_error = fifo_err[fifo_rd];
    end
  end

  // Control state: FSM, fetch pointer, counters and queue pointers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      fpc         <= RESET_VECTOR;
      outstanding <= 3'd0;
      stale       <= 3'd0;
      pcq_wr      <= 2'd0;
      pcq_rd      <= 2'd0;
      fifo_wr     <= 2'd0;
      fifo_rd     <= 2'd0;
      fifo_cnt    <= 3'd0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      stale       <= stale_nxt;
      // bit 1 of a redirect target survives so the first word reports it
      if (redirect_valid) begin
        fpc <= redirect_pc & 32'hFFFF_FFFE;
      end else if (accept) begin
        fpc <= {fpc[31:2] + 30'd1, 2'b00};
      end
      if (accept) begin
        pcq_wr <= pcq_wr + 2'd1;
      end
      if (rsp) begin
        pcq_rd <= pcq_rd + 2'd1;
      end
      if (redirect_valid) begin
        fifo_wr  <= 2'd0;
        fifo_rd  <= 2'd0;
        fifo_cnt <= 3'd0;
      end else begin
        fifo_wr  <= fifo_wr + {1'b0, push};
        fifo_rd  <= fifo_rd + {1'b0, pop};
        fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
      end
    end
  end

  // Data storage for the PC queue and response FIFO (not reset)
  always_ff @(posedge clock) begin
    if (accept) begin
      pcq[pcq_wr] <= fpc;
    end
    if (push) begin
      fifo_pc[fifo_wr]   <= rsp_pc;
      fifo_data[fifo_wr] <= mem_rdata;
      fifo_err[fifo_wr]  <= mem_rerror;
    end
  end

endmodule
